food_placer: RTL and testbench

- Parametrised successor to the free-running food-coordinate latch.
- On request, draws pseudo-random grid cells from an internal Galois LFSR.
- Rejects cells outside the playfield or occupied by the snake, then publishes a pixel-aligned food position with a valid flag.
- Sits between the game controller (request/collision events) and the VGA renderer/snake body store (occupancy query port).

---
 rtl/food_pkg.sv | 46 ++++
 rtl/lfsr_galois.sv | 18 +
 rtl/food_placer.sv | 148 ++++++++++++++
 tb/tb_food_placer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/food_pkg.sv
// Shared types and helpers for the food placer: FSM states, clog2 and Galois LFSR tap masks.
package food_pkg;

  typedef enum logic [2:0] {IDLE, DRAW, QUERY, WAIT, DONE} state_t;

  function automatic int unsigned clog2_u(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    return r;
  endfunction

  // Right-shifting Galois masks for maximal-length sequences, widths 8..32.
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    case (w)
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_B400;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Free-running right-shifting Galois LFSR with synchronous reload to SEED.
module lfsr_galois #(
  parameter int unsigned    W    = 16,
  parameter logic [W-1:0]   SEED = W'(1),
  parameter logic [W-1:0]   TAPS = W'(1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= SEED;
    else if (en) q <= (q >> 1) ^ (q[0] ? TAPS : '0);
  end

endmodule

// File: rtl/food_placer.sv
// Draws random playfield cells, rejects out-of-field or snake-occupied ones,
// and publishes a pixel-aligned food position.
module food_placer
  import food_pkg::*;
#(
  parameter int unsigned       COORD_W   = 10,
  parameter int unsigned       CELL_SH   = 3,
  parameter int unsigned       N_CX      = 80,
  parameter int unsigned       N_CY      = 60,
  parameter int unsigned       X_ORG     = 0,
  parameter int unsigned       Y_ORG     = 0,
  parameter int unsigned       LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1),
  parameter int unsigned       MAX_TRIES = 64,
  localparam int unsigned      CX_W      = clog2_u(N_CX),
  localparam int unsigned      CY_W      = clog2_u(N_CY)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  output logic               qry_valid,
  output logic [CX_W-1:0]    qry_cx,
  output logic [CY_W-1:0]    qry_cy,
  input  logic               qry_ready,
  input  logic               rsp_valid,
  input  logic               rsp_hit,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y,
  output logic               food_valid,
  output logic               busy,
  output logic               fail
);

  localparam int unsigned TRY_W = clog2_u(MAX_TRIES + 1);

  if (CX_W + CY_W > LFSR_W) begin : g_bad_lfsr_w
    $error("food_placer: CX_W+CY_W exceeds LFSR_W");
  end
  if (LFSR_W < 8 || LFSR_W > 32) begin : g_bad_taps
    $error("food_placer: LFSR_W outside tap table range 8..32");
  end
  if (MAX_TRIES == 0) begin : g_bad_tries
    $error("food_placer: MAX_TRIES must be nonzero");
  end

  state_t             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q;
  logic [CX_W-1:0]    draw_cx, cand_cx_q;
  logic [CY_W-1:0]    draw_cy, cand_cy_q;
  logic [TRY_W-1:0]   tries_q;
  logic [COORD_W-1:0] pix_x, pix_y;
  logic               in_range, exhausted;
  logic               unused_lfsr;

  lfsr_galois #(
    .W    (LFSR_W),
    .SEED (SEED),
    .TAPS (LFSR_W'(lfsr_taps(LFSR_W)))
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .q   (lfsr_q)
  );

  assign draw_cx     = lfsr_q[CX_W-1:0];
  assign draw_cy     = lfsr_q[CX_W+CY_W-1:CX_W];
  assign unused_lfsr = ^lfsr_q;
  assign in_range    = (32'(draw_cx) < N_CX) && (32'(draw_cy) < N_CY);
  assign exhausted   = (32'(tries_q) == MAX_TRIES);
  assign pix_x       = COORD_W'(X_ORG) + (COORD_W'(cand_cx_q) << CELL_SH);
  assign pix_y       = COORD_W'(Y_ORG) + (COORD_W'(cand_cy_q) << CELL_SH);
  assign qry_cx      = cand_cx_q;
  assign qry_cy      = cand_cy_q;

  always_ff @(posedge clk) begin : p_state
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin : p_next
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (req) state_d = DRAW;
      DRAW: begin
        if (exhausted)     state_d = DONE;
        else if (in_range) state_d = QUERY;
      end
      QUERY:   if (qry_ready) state_d = WAIT;
      WAIT:    if (rsp_valid) state_d = rsp_hit ? DRAW : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : p_out
    qry_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      DRAW, WAIT: busy = 1'b1;
      QUERY: begin
        busy      = 1'b1;
        qry_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Candidate, try counter and published food position.
  always_ff @(posedge clk) begin : p_data
    if (rst) begin
      cand_cx_q  <= '0;
      cand_cy_q  <= '0;
      tries_q    <= '0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      fail       <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (req) begin
            tries_q    <= '0;
            fail       <= 1'b0;
            food_valid <= 1'b0;
          end
        end
        DRAW: begin
          if (exhausted) begin
            fail <= 1'b1;
          end else begin
            cand_cx_q <= draw_cx;
            cand_cy_q <= draw_cy;
            tries_q   <= tries_q + TRY_W'(1);
          end
        end
        WAIT: begin
          if (rsp_valid && !rsp_hit) begin
            food_x     <= pix_x;
            food_y     <= pix_y;
            food_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_food_placer.sv
// Randomized self-checking bench for food_placer against a transaction-level
// model of the draw / reject / query search.
module tb_food_placer;
  import food_pkg::*;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned CELL_SH   = 3;
  localparam int unsigned N_CX      = 80;
  localparam int unsigned N_CY      = 60;
  localparam int unsigned X_ORG     = 16;
  localparam int unsigned Y_ORG     = 8;
  localparam int unsigned MAX_TRIES = 8;
  localparam logic [15:0] SEED      = 16'hACE1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               req = 1'b0;
  logic               qry_valid;
  logic [6:0]         qry_cx;
  logic [5:0]         qry_cy;
  logic               qry_ready = 1'b0;
  logic               rsp_valid = 1'b0;
  logic               rsp_hit = 1'b0;
  logic [COORD_W-1:0] food_x, food_y;
  logic               food_valid, busy, fail;

  food_placer #(
    .COORD_W(COORD_W), .CELL_SH(CELL_SH), .N_CX(N_CX), .N_CY(N_CY),
    .X_ORG(X_ORG), .Y_ORG(Y_ORG), .LFSR_W(16), .SEED(SEED), .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .qry_valid(qry_valid), .qry_cx(qry_cx), .qry_cy(qry_cy), .qry_ready(qry_ready),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .busy(busy), .fail(fail)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Polynomial x^16+x^14+x^13+x^11+1 in right-shifting Galois form.
  function automatic logic [15:0] lf_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [15:0] lf_adv(input logic [15:0] v, input int n);
    logic [15:0] r = v;
    for (int i = 0; i < n; i++) r = lf_step(r);
    return r;
  endfunction

  function automatic int cell_x(input logic [15:0] v); return int'(v) % 128; endfunction
  function automatic int cell_y(input logic [15:0] v); return (int'(v) / 128) % 64; endfunction
  function automatic bit in_field(input logic [15:0] v);
    return cell_x(v) < int'(N_CX) && cell_y(v) < int'(N_CY);
  endfunction

  // LFSR value during the current cycle, tracked by time alone.
  logic [15:0] m_lf;
  always @(posedge clk) m_lf <= rst ? SEED : lf_step(m_lf);

  int exp_cx[$];
  int exp_cy[$];
  bit exp_fail;
  int exp_lat, exp_fx, exp_fy;
  int prev_x = 0, prev_y = 0;

  // Predicts the queried cells, outcome and DRAW-to-DONE cycle count of one search.
  task automatic predict(input logic [15:0] v0, input int n_hit, input int k, input int m);
    logic [15:0] v = v0;
    int tries = 0;
    exp_cx.delete(); exp_cy.delete();
    exp_fail = 0; exp_lat = 0; exp_fx = 0; exp_fy = 0;
    forever begin
      if (tries == int'(MAX_TRIES)) begin exp_fail = 1; exp_lat += 1; break; end
      tries++;
      if (!in_field(v)) begin v = lf_step(v); exp_lat += 1; continue; end
      exp_cx.push_back(cell_x(v));
      exp_cy.push_back(cell_y(v));
      exp_lat += 3 + k + m;
      if (n_hit < 0 || exp_cx.size() <= n_hit) begin
        v = lf_adv(v, 3 + k + m);
      end else begin
        exp_fx = int'(X_ORG) + cell_x(v) * 8;
        exp_fy = int'(Y_ORG) + cell_y(v) * 8;
        break;
      end
    end
  endtask

  // Called at a negedge; issues req now and plays the snake store until the search ends.
  task automatic run_search(input string tag, input int n_hit, input int k, input int m,
                            input bit noise);
    int n = 0, qi = 0, sc = 0, rc = 0, phase = 0;
    bit done = 0;
    predict(lf_step(m_lf), n_hit, k, m);
    req = 1'b1;
    @(negedge clk);
    while (!done && n < 400) begin
      req = 1'b0; qry_ready = 1'b0; rsp_valid = 1'b0; rsp_hit = 1'b0;
      if (!busy) begin
        done = 1;
      end else begin
        if (noise && (n % 3 == 1)) req = 1'b1;
        if (phase == 0) begin
          if (sc > 0) check({tag, "_qry_hold"}, 32'(qry_valid), 1);
          if (qry_valid) begin
            if (sc == k) begin
              qry_ready = 1'b1;
              if (qi < exp_cx.size()) begin
                check({tag, "_qry_cx"}, 32'(qry_cx), exp_cx[qi]);
                check({tag, "_qry_cy"}, 32'(qry_cy), exp_cy[qi]);
              end else begin
                check({tag, "_extra_qry"}, qi, exp_cx.size());
              end
              phase = 1; rc = 0;
            end else begin
              sc++;
              if (noise) begin rsp_valid = 1'b1; rsp_hit = 1'($urandom); end
            end
          end
        end else if (rc == m) begin
          rsp_valid = 1'b1;
          rsp_hit = (n_hit < 0 || qi < n_hit);
          qi++; phase = 0; sc = 0;
        end else begin
          rc++;
        end
        @(negedge clk);
        n++;
      end
    end
    req = 1'b0; qry_ready = 1'b0; rsp_valid = 1'b0; rsp_hit = 1'b0;
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_queries"}, qi, exp_cx.size());
    check({tag, "_fail"}, 32'(fail), 32'(exp_fail));
    if (exp_fail) begin
      check({tag, "_x_kept"}, 32'(food_x), prev_x);
      check({tag, "_y_kept"}, 32'(food_y), prev_y);
      check({tag, "_valid"}, 32'(food_valid), 0);
    end else begin
      check({tag, "_food_x"}, 32'(food_x), exp_fx);
      check({tag, "_food_y"}, 32'(food_y), exp_fy);
      check({tag, "_valid"}, 32'(food_valid), 1);
      prev_x = exp_fx; prev_y = exp_fy;
    end
  endtask

  // Waits (bounded) for a start cycle whose first draw satisfies the chosen mode.
  task automatic pick_start(input int mode, input int n_hit, input int k, input int m,
                            output bit found);
    logic [15:0] v;
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      v = lf_step(m_lf);
      case (mode)
        0: found = in_field(v);
        1: found = !in_field(v);
        default: begin
          predict(v, n_hit, k, m);
          found = !exp_fail && exp_cx.size() == n_hit + 1;
        end
      endcase
      if (!found) @(negedge clk);
    end
  endtask

  initial begin
    bit found;
    int w;
    repeat (3) @(negedge clk);
    check("rst_lfsr", 32'(dut.u_lfsr.q), 32'(SEED));
    check("rst_food_valid", 32'(food_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_qry_valid", 32'(qry_valid), 0);
    check("rst_fail", 32'(fail), 0);
    rst = 1'b0;

    // Idle after reset: LFSR free-runs, nothing else moves.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_lfsr", 32'(dut.u_lfsr.q), 32'(m_lf));
      check("idle_busy", 32'(busy), 0);
      check("idle_qry", 32'(qry_valid), 0);
      check("idle_food_valid", 32'(food_valid), 0);
    end

    pick_start(0, 0, 0, 0, found);
    check("t2_pick", 32'(found), 1);
    run_search("t2", 0, 0, 0, 0);

    pick_start(1, 0, 1, 1, found);
    check("t3_pick", 32'(found), 1);
    run_search("t3", 0, 1, 1, 0);

    pick_start(2, 3, 0, 1, found);
    check("t4_pick", 32'(found), 1);
    run_search("t4", 3, 0, 1, 1);

    run_search("t5", -1, 0, 0, 0);
    check("t5_draws_le_max", 32'(exp_cx.size() <= int'(MAX_TRIES)), 1);
    check("t5_busy", 32'(busy), 0);

    // Reset in the middle of a stalled query handshake.
    pick_start(0, 0, 0, 0, found);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    w = 0;
    while (!qry_valid && w < 40) begin @(negedge clk); w++; end
    check("t6_qry_seen", 32'(qry_valid), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_state", 32'(dut.state_q), 32'(IDLE));
    check("t6_lfsr", 32'(dut.u_lfsr.q), 32'(SEED));
    check("t6_qry_valid", 32'(qry_valid), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_food_valid", 32'(food_valid), 0);
    check("t6_fail", 32'(fail), 0);
    check("t6_food_x", 32'(food_x), 0);
    check("t6_food_y", 32'(food_y), 0);
    prev_x = 0; prev_y = 0;
    repeat (2) @(negedge clk);
    run_search("t6_after", 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      run_search("rnd", int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
